// File: rtl/smem_pkg.sv
// smem_pkg: shared status codes, default widths and pass-through token layout for the SMEM pipeline
package smem_pkg;
  localparam logic [5:0] BUBBLE = 6'd0;
  localparam logic [5:0] BCK_INI = 6'd1;
  localparam logic [5:0] BCK_RUN = 6'd2;
  localparam logic [5:0] BCK_END = 6'd3;
  localparam int SMEM_SA_W = 64;
  localparam int SMEM_ADDR_W = 42;
  localparam int SMEM_BUCKET_SHIFT = 7;
  localparam int SMEM_ADDR_PAD = 4;
  localparam int SMEM_POS_W = 7;
  localparam int SMEM_RN_W = 10;
  localparam int SMEM_PAYLOAD_W = 256;
  localparam int SMEM_CNT_W = 32;
  typedef struct packed {
    logic [SMEM_SA_W-1:0] x1;
    logic [63:0] info;
    logic [31:0] sizes;
    logic [SMEM_POS_W-1:0] wr_addr;
    logic [SMEM_POS_W-1:0] rd_addr;
    logic [SMEM_SA_W-1:0] min_intv;
    logic [16:0] reserved;
    logic iteration_boundary;
  } smem_payload_t;
endpackage

// File: rtl/kl_bucket_calc.sv
// kl_bucket_calc: S1 k/l precompute registers and S2 sentinel-skip select with bucket addressing
module kl_bucket_calc import smem_pkg::*; #(
  parameter int SA_W = SMEM_SA_W,
  parameter int ADDR_W = SMEM_ADDR_W,
  parameter int BUCKET_SHIFT = SMEM_BUCKET_SHIFT,
  parameter int ADDR_PAD = SMEM_ADDR_PAD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [SA_W-1:0]   x0,
  input  logic [SA_W-1:0]   x2,
  input  logic [SA_W-1:0]   primary,
  output logic [SA_W-1:0]   k,
  output logic [SA_W-1:0]   l,
  output logic [ADDR_W-1:0] addr_k,
  output logic [ADDR_W-1:0] addr_l
);
  logic [SA_W-1:0] kt_q, kt_d, lt_q, lt_d, kt1_q, kt1_d, lt1_q, lt1_d, primary_q, primary_d;
  always_comb begin
    kt_d = en ? x0 - SA_W'(1) : kt_q;
    lt_d = en ? x0 - SA_W'(1) + x2 : lt_q;
    kt1_d = en ? x0 - SA_W'(2) : kt1_q;
    lt1_d = en ? x0 - SA_W'(2) + x2 : lt1_q;
    primary_d = en ? primary : primary_q;
    k = kt_q >= primary_q ? kt1_q : kt_q;
    l = lt_q >= primary_q ? lt1_q : lt_q;
    addr_k = ADDR_W'((k >> BUCKET_SHIFT) << ADDR_PAD);
    addr_l = ADDR_W'((l >> BUCKET_SHIFT) << ADDR_PAD);
  end
  always_ff @(posedge clk)
    if (!rst) begin
      kt_q <= '0;
      lt_q <= '0;
      kt1_q <= '0;
      lt1_q <= '0;
      primary_q <= '0;
    end else begin
      kt_q <= kt_d;
      lt_q <= lt_d;
      kt1_q <= kt1_d;
      lt1_q <= lt1_d;
      primary_q <= primary_d;
    end
endmodule

// File: rtl/bwd_kl_req_stage.sv
// bwd_kl_req_stage: two-stage elastic backward-extension stage emitting occurrence-bucket memory requests
module bwd_kl_req_stage import smem_pkg::*; #(
  parameter int SA_W = SMEM_SA_W,
  parameter int ADDR_W = SMEM_ADDR_W,
  parameter int BUCKET_SHIFT = SMEM_BUCKET_SHIFT,
  parameter int ADDR_PAD = SMEM_ADDR_PAD,
  parameter int POS_W = SMEM_POS_W,
  parameter int RN_W = SMEM_RN_W,
  parameter int PAYLOAD_W = SMEM_PAYLOAD_W,
  parameter int CNT_W = SMEM_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           in_status,
  input  logic [RN_W-1:0]      in_read_num,
  input  logic [SA_W-1:0]      in_x0,
  input  logic [SA_W-1:0]      in_x2,
  input  logic [SA_W-1:0]      in_primary,
  input  logic [POS_W-1:0]     in_bwd_i,
  input  logic [POS_W-1:0]     in_mem_wr_addr,
  input  logic                 in_finish,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 qry_valid,
  output logic [RN_W-1:0]      qry_read_num,
  output logic [POS_W-1:0]     qry_pos,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [5:0]           out_status,
  output logic [RN_W-1:0]      out_read_num,
  output logic [SA_W-1:0]      out_k,
  output logic [SA_W-1:0]      out_l,
  output logic [ADDR_W-1:0]    out_addr_k,
  output logic [ADDR_W-1:0]    out_addr_l,
  output logic                 out_same_bucket,
  output logic                 out_req,
  output logic [POS_W-1:0]     out_bwd_i,
  output logic [POS_W-1:0]     out_mem_wr_addr,
  output logic [POS_W-1:0]     out_mem_size,
  output logic                 out_finish,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CNT_W-1:0]     req_count,
  output logic [CNT_W-1:0]     merge_count
);
  typedef struct packed {
    logic [5:0] status;
    logic [RN_W-1:0] read_num;
    logic [POS_W-1:0] bwd_i;
    logic [POS_W-1:0] mem_wr_addr;
    logic [PAYLOAD_W-1:0] payload;
  } s1_t;
  typedef struct packed {
    logic [5:0] status;
    logic [RN_W-1:0] read_num;
    logic [SA_W-1:0] k;
    logic [SA_W-1:0] l;
    logic [ADDR_W-1:0] addr_k;
    logic [ADDR_W-1:0] addr_l;
    logic same_bucket;
    logic req;
    logic [POS_W-1:0] bwd_i;
    logic [POS_W-1:0] mem_wr_addr;
    logic [POS_W-1:0] mem_size;
    logic finish;
    logic [PAYLOAD_W-1:0] payload;
  } s2_t;
  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d, run_tok, end_tok;
  logic s1_valid_q, s1_valid_d, out_valid_q, out_valid_d, qry_valid_q, qry_valid_d;
  logic [RN_W-1:0] qry_read_num_q, qry_read_num_d;
  logic [POS_W-1:0] qry_pos_q, qry_pos_d;
  logic [CNT_W-1:0] req_count_q, req_count_d, merge_count_q, merge_count_d;
  logic [5:0] eff_status;
  logic s2_free, s1_move, s1_load, out_fire;
  logic [SA_W-1:0] k, l;
  logic [ADDR_W-1:0] addr_k, addr_l;
  kl_bucket_calc #(
    .SA_W(SA_W), .ADDR_W(ADDR_W), .BUCKET_SHIFT(BUCKET_SHIFT), .ADDR_PAD(ADDR_PAD)
  ) u_calc (
    .clk(clk), .rst(rst), .en(s1_load), .x0(in_x0), .x2(in_x2), .primary(in_primary),
    .k(k), .l(l), .addr_k(addr_k), .addr_l(addr_l)
  );
  always_comb begin
    eff_status = in_finish ? BCK_END : in_status;
    s2_free = !out_valid_q || out_ready;
    s1_move = s1_valid_q && s2_free;
    in_ready = !s1_valid_q || s1_move;
    s1_load = in_valid && in_ready && eff_status != BUBBLE;
    out_fire = out_valid_q && out_ready;
    s1_valid_d = s1_load || (s1_valid_q && !s1_move);
    out_valid_d = s1_move || (out_valid_q && !out_ready);
    qry_valid_d = s1_load;
    qry_read_num_d = s1_load ? in_read_num : qry_read_num_q;
    qry_pos_d = s1_load ? in_bwd_i : qry_pos_q;
    s1_d = s1_load ? s1_t'{status: eff_status, read_num: in_read_num, bwd_i: in_bwd_i,
                           mem_wr_addr: in_mem_wr_addr, payload: in_payload} : s1_q;
    run_tok = s2_t'{status: BCK_RUN, read_num: s1_q.read_num, k: k, l: l, addr_k: addr_k,
                    addr_l: addr_l, same_bucket: addr_k == addr_l, req: 1'b1, bwd_i: s1_q.bwd_i,
                    mem_wr_addr: s1_q.mem_wr_addr,
                    mem_size: s1_q.status == BCK_INI ? {POS_W{1'b0}} : s1_q.mem_wr_addr,
                    finish: 1'b0, payload: s1_q.payload};
    // a finishing token carries only its read number and final size downstream
    end_tok = s2_t'{status: BUBBLE, read_num: s1_q.read_num, mem_size: s1_q.mem_wr_addr,
                    finish: 1'b1, default: '0};
    s2_d = !s1_move ? s2_q : s1_q.status == BCK_END ? end_tok : run_tok;
    req_count_d = req_count_q + CNT_W'(out_fire && s2_q.req);
    merge_count_d = merge_count_q + CNT_W'(out_fire && s2_q.req && s2_q.same_bucket);
  end
  always_ff @(posedge clk)
    if (!rst) begin
      s1_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      qry_valid_q <= 1'b0;
      qry_read_num_q <= '0;
      qry_pos_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      req_count_q <= '0;
      merge_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      out_valid_q <= out_valid_d;
      qry_valid_q <= qry_valid_d;
      qry_read_num_q <= qry_read_num_d;
      qry_pos_q <= qry_pos_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      req_count_q <= req_count_d;
      merge_count_q <= merge_count_d;
    end
  assign qry_valid = qry_valid_q;
  assign qry_read_num = qry_read_num_q;
  assign qry_pos = qry_pos_q;
  assign out_valid = out_valid_q;
  assign out_status = s2_q.status;
  assign out_read_num = s2_q.read_num;
  assign out_k = s2_q.k;
  assign out_l = s2_q.l;
  assign out_addr_k = s2_q.addr_k;
  assign out_addr_l = s2_q.addr_l;
  assign out_same_bucket = s2_q.same_bucket;
  assign out_req = s2_q.req;
  assign out_bwd_i = s2_q.bwd_i;
  assign out_mem_wr_addr = s2_q.mem_wr_addr;
  assign out_mem_size = s2_q.mem_size;
  assign out_finish = s2_q.finish;
  assign out_payload = s2_q.payload;
  assign req_count = req_count_q;
  assign merge_count = merge_count_q;
endmodule

// File: tb/tb_bwd_kl_req_stage.sv
// tb_bwd_kl_req_stage: directed vectors feeding a queue scoreboard checked by an independent output monitor
module tb_bwd_kl_req_stage;
  import smem_pkg::*;
  localparam int SA_W = 64, ADDR_W = 42, POS_W = 7, RN_W = 10, PAYLOAD_W = 256, CNT_W = 32;
  localparam logic [255:0] P1 = {8{32'h1111_0001}};
  localparam logic [255:0] P2 = {8{32'h2222_0002}};
  localparam logic [255:0] P3 = {8{32'h3333_0003}};
  localparam logic [255:0] P4 = {8{32'h4444_0004}};
  localparam logic [255:0] P5 = {8{32'h5555_0005}};
  localparam logic [255:0] P6 = {8{32'hA5A5_5A5A}};
  typedef struct packed {
    logic [5:0] status;
    logic [RN_W-1:0] read_num;
    logic [SA_W-1:0] k;
    logic [SA_W-1:0] l;
    logic [ADDR_W-1:0] addr_k;
    logic [ADDR_W-1:0] addr_l;
    logic same_bucket;
    logic req;
    logic [POS_W-1:0] bwd_i;
    logic [POS_W-1:0] mem_wr_addr;
    logic [POS_W-1:0] mem_size;
    logic finish;
    logic [PAYLOAD_W-1:0] payload;
  } exp_t;

  logic clk = 1'b0, rst = 1'b0;
  logic in_valid, in_ready, in_finish, qry_valid, out_valid, out_ready, out_same_bucket, out_req, out_finish;
  logic [5:0] in_status, out_status;
  logic [RN_W-1:0] in_read_num, qry_read_num, out_read_num;
  logic [SA_W-1:0] in_x0, in_x2, in_primary, out_k, out_l;
  logic [POS_W-1:0] in_bwd_i, in_mem_wr_addr, qry_pos, out_bwd_i, out_mem_wr_addr, out_mem_size;
  logic [PAYLOAD_W-1:0] in_payload, out_payload;
  logic [ADDR_W-1:0] out_addr_k, out_addr_l;
  logic [CNT_W-1:0] req_count, merge_count;

  exp_t sb[$];
  exp_t act, snap, popped;
  logic stalled = 1'b0;
  logic [CNT_W-1:0] m_req = '0, m_merge = '0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  bwd_kl_req_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_status(in_status),
    .in_read_num(in_read_num), .in_x0(in_x0), .in_x2(in_x2), .in_primary(in_primary),
    .in_bwd_i(in_bwd_i), .in_mem_wr_addr(in_mem_wr_addr), .in_finish(in_finish),
    .in_payload(in_payload), .qry_valid(qry_valid), .qry_read_num(qry_read_num), .qry_pos(qry_pos),
    .out_valid(out_valid), .out_ready(out_ready), .out_status(out_status),
    .out_read_num(out_read_num), .out_k(out_k), .out_l(out_l), .out_addr_k(out_addr_k),
    .out_addr_l(out_addr_l), .out_same_bucket(out_same_bucket), .out_req(out_req),
    .out_bwd_i(out_bwd_i), .out_mem_wr_addr(out_mem_wr_addr), .out_mem_size(out_mem_size),
    .out_finish(out_finish), .out_payload(out_payload), .req_count(req_count),
    .merge_count(merge_count)
  );

  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, a, x);
    end
  endtask

  function automatic exp_t run(input logic [RN_W-1:0] rn, input logic [63:0] k, l,
                               input logic [ADDR_W-1:0] ak, al, input logic same,
                               input logic [6:0] bwd, wr, sz, input logic [255:0] pl);
    run = '{status: BCK_RUN, read_num: rn, k: k, l: l, addr_k: ak, addr_l: al, same_bucket: same,
            req: 1'b1, bwd_i: bwd, mem_wr_addr: wr, mem_size: sz, finish: 1'b0, payload: pl};
  endfunction

  function automatic exp_t fin(input logic [RN_W-1:0] rn, input logic [6:0] sz);
    fin = '0;
    fin.status = BUBBLE;
    fin.read_num = rn;
    fin.mem_size = sz;
    fin.finish = 1'b1;
  endfunction

  task automatic send(input logic [5:0] st, input logic f, input logic [RN_W-1:0] rn,
                      input logic [63:0] x0, x2, pri, input logic [6:0] bwd, wr,
                      input logic [255:0] pl, input logic has_exp, input exp_t ex);
    logic rdy, acc;
    acc = 1'b0;
    in_valid = 1'b1; in_status = st; in_finish = f; in_read_num = rn; in_x0 = x0; in_x2 = x2;
    in_primary = pri; in_bwd_i = bwd; in_mem_wr_addr = wr; in_payload = pl;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      acc = rdy;
    end
    #1 in_valid = 1'b0;
    chk("accept", {63'd0, acc}, 64'd1);
    if (acc && has_exp) begin
      sb.push_back(ex);
      chk("qry_valid", {63'd0, qry_valid}, 64'd1);
      chk("qry_read_num", {54'd0, qry_read_num}, {54'd0, rn});
      chk("qry_pos", {57'd0, qry_pos}, {57'd0, bwd});
    end else if (acc) chk("qry_bubble", {63'd0, qry_valid}, 64'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drain", {63'd0, sb.size() == 0 && !out_valid}, 64'd1);
  endtask

  always @(negedge clk) begin
    act = {out_status, out_read_num, out_k, out_l, out_addr_k, out_addr_l, out_same_bucket, out_req,
           out_bwd_i, out_mem_wr_addr, out_mem_size, out_finish, out_payload};
    if (!rst) begin
      sb.delete();
      m_req = '0;
      m_merge = '0;
      stalled = 1'b0;
    end else begin
      chk("req_count", {32'd0, req_count}, {32'd0, m_req});
      chk("merge_count", {32'd0, merge_count}, {32'd0, m_merge});
      if (stalled) begin
        checks++;
        if (act !== snap) begin
          errors++;
          $display("FAIL hold_stable: got %h expected %h", act, snap);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got %h expected nothing", act);
        end else begin
          popped = sb.pop_front();
          if (act !== popped) begin
            errors++;
            $display("FAIL out_token rn=%0d: got %h expected %h", popped.read_num, act, popped);
          end
          if (popped.req) begin
            m_req = m_req + 1;
            if (popped.same_bucket) m_merge = m_merge + 1;
          end
        end
      end
      stalled = out_valid && !out_ready;
      snap = act;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    in_valid = 0; in_status = 0; in_finish = 0; in_read_num = 0; in_x0 = 0; in_x2 = 0;
    in_primary = 0; in_bwd_i = 0; in_mem_wr_addr = 0; in_payload = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_qry_valid", {63'd0, qry_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_status", {58'd0, out_status}, {58'd0, BUBBLE});
    chk("rst_k", out_k, 64'd0);
    chk("rst_req_count", {32'd0, req_count}, 64'd0);
    out_ready = 1'b1;
    // basic tokens, including first-token latency
    send(BCK_RUN, 0, 1, 100, 50, 120, 10, 3, P1, 1, run(1, 99, 148, 42'h0, 42'h10, 0, 10, 3, 3, P1));
    chk("lat_n1", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1 chk("lat_n2", {63'd0, out_valid}, 64'd1);
    send(BCK_INI, 0, 2, 64'h1000, 3, 0, 20, 5, P2, 1,
         run(2, 64'hFFE, 64'h1001, 42'h1F0, 42'h200, 0, 20, 5, 0, P2));
    send(BCK_RUN, 0, 3, 200, 10, 1000, 30, 7, P3, 1, run(3, 199, 209, 42'h10, 42'h10, 1, 30, 7, 7, P3));
    drain();
    chk("cnt_req_a", {32'd0, req_count}, 64'd3);
    chk("cnt_merge_a", {32'd0, merge_count}, 64'd1);
    send(BCK_RUN, 1, 5, 77, 5, 3, 11, 9, P4, 1, fin(5, 9));
    send(BCK_END, 0, 6, 1, 2, 3, 12, 2, P5, 1, fin(6, 2));
    drain();
    chk("cnt_req_b", {32'd0, req_count}, 64'd3);
    chk("cnt_merge_b", {32'd0, merge_count}, 64'd1);
    // backpressure: two tokens fill the stages, the rest wait
    out_ready = 1'b0;
    fork
      begin
        send(BCK_RUN, 0, 7, 1000, 100, 500, 1, 4, P6, 1,
             run(7, 998, 1098, 42'h70, 42'h80, 0, 1, 4, 4, P6));
        send(BCK_INI, 0, 8, 1, 0, 0, 2, 6, P1, 1,
             run(8, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 42'h3FF_FFFF_FFF0,
                 42'h3FF_FFFF_FFF0, 1, 2, 6, 0, P1));
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
        send(BUBBLE, 0, 9, 5, 5, 5, 9, 9, P2, 0, '0);
        send(BCK_RUN, 0, 10, 128, 1, 200, 3, 5, P3, 1, run(10, 127, 128, 42'h0, 42'h10, 0, 3, 5, 5, P3));
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("cnt_req_c", {32'd0, req_count}, 64'd6);
    chk("cnt_merge_c", {32'd0, merge_count}, 64'd2);
    // full-rate stream with an interleaved bubble
    send(BCK_RUN, 0, 11, 300, 0, 0, 8, 3, P4, 1, run(11, 298, 298, 42'h20, 42'h20, 1, 8, 3, 3, P4));
    send(BCK_INI, 1, 12, 9, 9, 9, 9, 8, P5, 1, fin(12, 8));
    send(BCK_INI, 0, 13, 5, 2, 4, 4, 7, P6, 1, run(13, 3, 5, 42'h0, 42'h0, 1, 4, 7, 0, P6));
    send(BUBBLE, 0, 0, 1, 1, 1, 1, 1, P1, 0, '0);
    send(BCK_RUN, 0, 14, 10, 20, 9, 5, 2, P2, 1, run(14, 8, 28, 42'h0, 42'h0, 1, 5, 2, 2, P2));
    drain();
    chk("cnt_req_d", {32'd0, req_count}, 64'd9);
    chk("cnt_merge_d", {32'd0, merge_count}, 64'd5);
    // reset with both stages occupied
    out_ready = 1'b0;
    send(BCK_RUN, 0, 20, 100, 50, 120, 1, 1, P3, 1, run(20, 99, 148, 42'h0, 42'h10, 0, 1, 1, 1, P3));
    send(BCK_RUN, 0, 21, 100, 50, 120, 1, 1, P3, 1, run(21, 99, 148, 42'h0, 42'h10, 0, 1, 1, 1, P3));
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    chk("rst2_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst2_qry_valid", {63'd0, qry_valid}, 64'd0);
    chk("rst2_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst2_req_count", {32'd0, req_count}, 64'd0);
    chk("rst2_merge_count", {32'd0, merge_count}, 64'd0);
    chk("rst2_status", {58'd0, out_status}, {58'd0, BUBBLE});
    chk("rst2_payload_zero", {63'd0, out_payload == '0}, 64'd1);
    out_ready = 1'b1;
    send(BCK_RUN, 0, 22, 64'h10000, 256, 64'h20000, 6, 1, P4, 1,
         run(22, 64'hFFFF, 64'h100FF, 42'h1FF0, 42'h2010, 0, 6, 1, 1, P4));
    chk("rst2_lat_n1", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1 chk("rst2_lat_n2", {63'd0, out_valid}, 64'd1);
    drain();
    chk("cnt_req_e", {32'd0, req_count}, 64'd1);
    chk("cnt_merge_e", {32'd0, merge_count}, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
